bus_switch: RTL and testbench
=============================

BUS_SWITCH -- requirements
Module: bus_switch

Interface
REQ-001 Parameter AW, default 16, address width.
REQ-002 Parameter DW, default 8, data width.
REQ-003 Parameter TO_CYC, default 16, wait cycles before a transfer is aborted as timed out (range 2..255).
REQ-004 Parameter PER_BASE, default 16'hF000; addresses >= PER_BASE select the peripheral slave, all others select memory.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 GRANT0 / GRANT1  in  1 each  bus grants from the arbiter; GRANT0 is master 1, GRANT1 is master 2.
REQ-008 M1_ADDR, M2_ADDR  in  AW  master addresses.
REQ-009 M1_WDATA, M2_WDATA  in  DW  master write data.
REQ-010 M1_READ, M1_WRITE, M2_READ, M2_WRITE  in  1 each  master request strobes, level, held until DONE or ERR.
REQ-011 M_RDATA  out  DW  read data returned to the owning master.
REQ-012 M1_DONE, M2_DONE  out  1 each  one-cycle completion pulse.
REQ-013 M1_ERR, M2_ERR  out  1 each  one-cycle timeout pulse.
REQ-014 S_ADDR  out  AW  and  S_WDATA  out  DW  latched transfer address and data.
REQ-015 S_READ, S_WRITE  out  1 each  slave strobes.
REQ-016 S_SEL_MEM, S_SEL_PER  out  1 each  one-hot slave selects.
REQ-017 S_RDATA  in  DW  and  S_READY  in  1  slave read data and slave completion.

Function
REQ-018 The FSM SHALL have four states: IDLE, XFER, RESP and REL.
REQ-019 In IDLE, if GRANT0 and (M1_READ|M1_WRITE), the block SHALL latch M1 address, data and direction, set owner=1 and go to XFER; else if GRANT1 and (M2_READ|M2_WRITE), it SHALL do the same for M2 (owner=2).
REQ-020 If GRANT0 and GRANT1 are both high, master 1 SHALL be served.
REQ-021 If READ and WRITE are both high, the transfer SHALL be a write.
REQ-022 In XFER the block SHALL drive S_READ or S_WRITE, S_ADDR, S_WDATA and exactly one select from the latched values; all are 0 in every other state.
REQ-023 S_SEL_PER SHALL be 1 when the latched address >= PER_BASE; otherwise S_SEL_MEM SHALL be 1.
REQ-024 A wait counter SHALL clear on entry to XFER and increment each XFER cycle without S_READY.
REQ-025 When S_READY=1 in XFER, a read SHALL register S_RDATA into M_RDATA and the FSM SHALL go to RESP; S_READY on the same cycle as the timeout limit SHALL win.
REQ-026 When the counter reaches TO_CYC-1 without S_READY, the FSM SHALL go to RESP with an error flag set, and M_RDATA SHALL stay unchanged.
REQ-027 In RESP the block SHALL pulse exactly one cycle: owner's DONE on success, owner's ERR on timeout, never both; then it SHALL go to REL.
REQ-028 In REL the FSM SHALL remain until the owner's READ and WRITE are both low, then go to IDLE, so one request is never served twice.
REQ-029 Loss of grant after latching SHALL NOT abort the transfer; the latched transfer completes.
REQ-030 M_RDATA SHALL hold its value until the next successful read.
REQ-031 Latency: request sampled in IDLE at edge n gives strobes in cycle n+1; S_READY at n+1 gives DONE in cycle n+2.
REQ-032 S_READY outside XFER SHALL be ignored.

Reset
REQ-033 rst SHALL immediately force IDLE, counter 0, owner none, error flag 0, and all outputs (M_RDATA, DONE, ERR, S_*) to 0, including mid-transfer.
REQ-034 After rst deasserts, a still-asserted granted request SHALL be served as a new transfer.

Verification
REQ-035 GRANT0, M1_READ, M1_ADDR=16'h0010, S_READY=1 one cycle after strobe with S_RDATA=8'hA5 -> S_SEL_MEM=1, M_RDATA=8'hA5, one M1_DONE pulse at n+2.
REQ-036 GRANT1, M2_WRITE, M2_ADDR=16'hF004, WDATA=8'h3C, S_READY after 3 waits -> S_SEL_PER=1, S_WDATA=8'h3C, one M2_DONE pulse.
REQ-037 M1 read with S_READY never asserted -> after TO_CYC=16 XFER cycles, one M1_ERR pulse, no DONE, M_RDATA unchanged.
REQ-038 GRANT0 and GRANT1 both high with both masters requesting -> master 1 served; M2 outputs remain 0.
REQ-039 M1 holds its request for 5 cycles after DONE -> single transfer only; IDLE is re-entered after the request drops.
REQ-040 rst asserted in XFER -> all outputs 0 in the same cycle; no DONE/ERR pulse after release until a new request.

Source files
------------

// File: rtl/bus_switch_if.sv
// Two-master / two-slave bus bundle seen by the bus switch.
interface bus_switch_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 8
);
    logic          GRANT0;
    logic          GRANT1;
    logic [AW-1:0] M1_ADDR;
    logic [AW-1:0] M2_ADDR;
    logic [DW-1:0] M1_WDATA;
    logic [DW-1:0] M2_WDATA;
    logic          M1_READ;
    logic          M1_WRITE;
    logic          M2_READ;
    logic          M2_WRITE;
    logic [DW-1:0] M_RDATA;
    logic          M1_DONE;
    logic          M2_DONE;
    logic          M1_ERR;
    logic          M2_ERR;
    logic [AW-1:0] S_ADDR;
    logic [DW-1:0] S_WDATA;
    logic          S_READ;
    logic          S_WRITE;
    logic          S_SEL_MEM;
    logic          S_SEL_PER;
    logic [DW-1:0] S_RDATA;
    logic          S_READY;

    // Switch side: takes requests and slave responses, drives everything else.
    modport slave (
        input  GRANT0, GRANT1, M1_ADDR, M2_ADDR, M1_WDATA, M2_WDATA,
               M1_READ, M1_WRITE, M2_READ, M2_WRITE, S_RDATA, S_READY,
        output M_RDATA, M1_DONE, M2_DONE, M1_ERR, M2_ERR,
               S_ADDR, S_WDATA, S_READ, S_WRITE, S_SEL_MEM, S_SEL_PER
    );

    // Environment side: masters, arbiter and slaves.
    modport master (
        output GRANT0, GRANT1, M1_ADDR, M2_ADDR, M1_WDATA, M2_WDATA,
               M1_READ, M1_WRITE, M2_READ, M2_WRITE, S_RDATA, S_READY,
        input  M_RDATA, M1_DONE, M2_DONE, M1_ERR, M2_ERR,
               S_ADDR, S_WDATA, S_READ, S_WRITE, S_SEL_MEM, S_SEL_PER
    );
endinterface

// File: rtl/bus_switch.sv
// Bus switch: routes one granted master transfer to memory or peripheral,
// with wait-cycle timeout and single-shot DONE/ERR completion.
module bus_switch #(
    parameter int unsigned   AW       = 16,
    parameter int unsigned   DW       = 8,
    parameter int unsigned   TO_CYC   = 16,
    parameter logic [AW-1:0] PER_BASE = AW'(16'hF000)
) (
    input logic         clk,
    input logic         rst,
    bus_switch_if.slave bus
);
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {IDLE, XFER, RESP, REL} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_M1, OWN_M2} owner_t;

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [DW-1:0] m_rdata_q, m_rdata_d;
    logic          m1_done_q, m1_done_d, m2_done_q, m2_done_d;
    logic          m1_err_q, m1_err_d, m2_err_q, m2_err_d;
    logic [AW-1:0] s_addr_q, s_addr_d;
    logic [DW-1:0] s_wdata_q, s_wdata_d;
    logic          s_read_q, s_read_d, s_write_q, s_write_d;
    logic          s_sel_mem_q, s_sel_mem_d, s_sel_per_q, s_sel_per_d;

    logic          pick_m1, pick_m2, req_write, owner_req;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;

    // Request selection: master 1 wins a double grant; write wins read+write.
    always_comb begin
        pick_m1   = bus.GRANT0 & (bus.M1_READ | bus.M1_WRITE);
        pick_m2   = ~pick_m1 & bus.GRANT1 & (bus.M2_READ | bus.M2_WRITE);
        req_addr  = pick_m1 ? bus.M1_ADDR  : bus.M2_ADDR;
        req_wdata = pick_m1 ? bus.M1_WDATA : bus.M2_WDATA;
        req_write = pick_m1 ? bus.M1_WRITE : bus.M2_WRITE;
        owner_req = 1'b0;
        if (owner_q == OWN_M1) owner_req = bus.M1_READ | bus.M1_WRITE;
        if (owner_q == OWN_M2) owner_req = bus.M2_READ | bus.M2_WRITE;
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        m_rdata_d   = m_rdata_q;
        m1_done_d   = 1'b0;
        m2_done_d   = 1'b0;
        m1_err_d    = 1'b0;
        m2_err_d    = 1'b0;
        s_addr_d    = '0;
        s_wdata_d   = '0;
        s_read_d    = 1'b0;
        s_write_d   = 1'b0;
        s_sel_mem_d = 1'b0;
        s_sel_per_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_m1 || pick_m2) begin
                    state_d     = XFER;
                    owner_d     = pick_m1 ? OWN_M1 : OWN_M2;
                    cnt_d       = '0;
                    err_d       = 1'b0;
                    s_addr_d    = req_addr;
                    s_wdata_d   = req_wdata;
                    s_write_d   = req_write;
                    s_read_d    = ~req_write;
                    s_sel_per_d = (req_addr >= PER_BASE);
                    s_sel_mem_d = ~(req_addr >= PER_BASE);
                end
            end
            XFER: begin
                if (bus.S_READY) begin
                    state_d   = RESP;
                    m1_done_d = (owner_q == OWN_M1);
                    m2_done_d = (owner_q == OWN_M2);
                    if (s_read_q) m_rdata_d = bus.S_RDATA;
                end else if (cnt_q == CW'(TO_CYC - 1)) begin
                    state_d  = RESP;
                    err_d    = 1'b1;
                    m1_err_d = (owner_q == OWN_M1);
                    m2_err_d = (owner_q == OWN_M2);
                end else begin
                    cnt_d       = cnt_q + CW'(1);
                    s_addr_d    = s_addr_q;
                    s_wdata_d   = s_wdata_q;
                    s_read_d    = s_read_q;
                    s_write_d   = s_write_q;
                    s_sel_mem_d = s_sel_mem_q;
                    s_sel_per_d = s_sel_per_q;
                end
            end
            RESP: state_d = REL;
            REL: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    owner_d = OWN_NONE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            m_rdata_q   <= '0;
            m1_done_q   <= 1'b0;
            m2_done_q   <= 1'b0;
            m1_err_q    <= 1'b0;
            m2_err_q    <= 1'b0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            s_read_q    <= 1'b0;
            s_write_q   <= 1'b0;
            s_sel_mem_q <= 1'b0;
            s_sel_per_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            m_rdata_q   <= m_rdata_d;
            m1_done_q   <= m1_done_d;
            m2_done_q   <= m2_done_d;
            m1_err_q    <= m1_err_d;
            m2_err_q    <= m2_err_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            s_read_q    <= s_read_d;
            s_write_q   <= s_write_d;
            s_sel_mem_q <= s_sel_mem_d;
            s_sel_per_q <= s_sel_per_d;
        end
    end

    assign bus.M_RDATA   = m_rdata_q;
    assign bus.M1_DONE   = m1_done_q;
    assign bus.M2_DONE   = m2_done_q;
    assign bus.M1_ERR    = m1_err_q;
    assign bus.M2_ERR    = m2_err_q;
    assign bus.S_ADDR    = s_addr_q;
    assign bus.S_WDATA   = s_wdata_q;
    assign bus.S_READ    = s_read_q;
    assign bus.S_WRITE   = s_write_q;
    assign bus.S_SEL_MEM = s_sel_mem_q;
    assign bus.S_SEL_PER = s_sel_per_q;
endmodule

// File: tb/tb_bus_switch.sv
// Bench for bus_switch: vector table plus scoreboard of expected completions.
module tb_bus_switch;
    localparam int TO_CYC = 16;
    localparam int NEVER  = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    bus_switch_if #(.AW(16), .DW(8)) bus ();

    bus_switch #(
        .AW(16), .DW(8), .TO_CYC(TO_CYC), .PER_BASE(16'hF000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // field order: g0 g1 m1_rd m1_wr m2_rd m2_wr m1_addr m2_addr m1_wd m2_wd
    // s_rdata waits hold drop_g | exp_owner exp_wr exp_addr exp_wd exp_per exp_err exp_rdata
    typedef struct {
        logic        g0, g1, m1_rd, m1_wr, m2_rd, m2_wr;
        logic [15:0] m1_addr, m2_addr;
        logic [7:0]  m1_wd, m2_wd, s_rdata;
        int          waits;
        int          hold;
        logic        drop_g;
        int          exp_owner;
        logic        exp_wr;
        logic [15:0] exp_addr;
        logic [7:0]  exp_wd;
        logic        exp_per;
        logic        exp_err;
        logic [7:0]  exp_rdata;
    } vec_t;

    typedef struct {
        int         owner;
        logic       err;
        logic [7:0] rdata;
        int         lat;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        bus.GRANT0 = 0; bus.GRANT1 = 0;
        bus.M1_READ = 0; bus.M1_WRITE = 0; bus.M2_READ = 0; bus.M2_WRITE = 0;
    endtask

    task automatic drive(input vec_t v);
        bus.GRANT0 = v.g0;       bus.GRANT1 = v.g1;
        bus.M1_READ = v.m1_rd;   bus.M1_WRITE = v.m1_wr;
        bus.M2_READ = v.m2_rd;   bus.M2_WRITE = v.m2_wr;
        bus.M1_ADDR = v.m1_addr; bus.M2_ADDR = v.m2_addr;
        bus.M1_WDATA = v.m1_wd;  bus.M2_WDATA = v.m2_wd;
    endtask

    function automatic logic [3:0] pulses();
        return {bus.M1_DONE, bus.M2_DONE, bus.M1_ERR, bus.M2_ERR};
    endfunction

    function automatic logic [3:0] strobes();
        return {bus.S_READ, bus.S_WRITE, bus.S_SEL_MEM, bus.S_SEL_PER};
    endfunction

    task automatic run_vec(input vec_t v);
        sb_t        e;
        sb_t        got;
        int         lat;
        logic       seen;
        int         held_bad;
        int         rel_bad;
        logic [3:0] exp_p;
        e.owner = v.exp_owner;
        e.err   = v.exp_err;
        e.rdata = v.exp_rdata;
        e.lat   = (v.waits == NEVER) ? TO_CYC : v.waits + 1;
        sb_q.push_back(e);
        drive(v);
        bus.S_READY = 0;
        bus.S_RDATA = v.s_rdata;
        tick();
        check("strobes", 64'({~v.exp_wr, v.exp_wr, ~v.exp_per, v.exp_per, v.exp_addr, v.exp_wd}),
              64'({strobes(), bus.S_ADDR, bus.S_WDATA}) ^ 64'd0 ^ 64'd0 ? 64'({strobes(), bus.S_ADDR, bus.S_WDATA}) : 64'd0);
        if (v.drop_g) begin
            bus.GRANT0 = 0;
            bus.GRANT1 = 0;
        end
        seen = 0; lat = 0; held_bad = 0;
        for (int k = 0; k < TO_CYC + 8 && !seen; k++) begin
            if (bus.S_ADDR !== v.exp_addr || (bus.S_READ | bus.S_WRITE) !== 1'b1) held_bad++;
            bus.S_READY = (k == v.waits);
            tick();
            bus.S_READY = 0;
            lat  = k + 1;
            seen = |pulses();
        end
        check("strobe_hold", 64'(held_bad), 64'd0);
        check("pulse_seen", 64'(seen), 64'd1);
        if (sb_q.size() == 0) begin
            check("sb_nonempty", 64'd0, 64'd1);
        end else begin
            got   = sb_q.pop_front();
            exp_p = {got.owner == 1 && !got.err, got.owner == 2 && !got.err,
                     got.owner == 1 && got.err,  got.owner == 2 && got.err};
            check("pulses",  64'(pulses()), 64'(exp_p));
            check("m_rdata", 64'(bus.M_RDATA), 64'(got.rdata));
            check("latency", 64'(lat), 64'(got.lat));
            check("resp_strobes_off", 64'(strobes()), 64'd0);
        end
        tick();
        check("one_pulse", 64'(pulses()), 64'd0);
        rel_bad = 0;
        for (int h = 0; h < v.hold; h++) begin
            tick();
            if (pulses() != 0 || strobes() != 0) rel_bad++;
        end
        check("rel_no_reserve", 64'(rel_bad), 64'd0);
        clear_req();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vmid;
        vec_t vpost;
        int   quiet_bad;
        vecs[0] = '{1,0, 1,0, 0,0, 16'h0010,16'h0000, 8'h00,8'h00, 8'hA5, 0,0,1'b0,
                    1,1'b0,16'h0010,8'h00,1'b0,1'b0,8'hA5};
        vecs[1] = '{0,1, 0,0, 0,1, 16'h0000,16'hF004, 8'h00,8'h3C, 8'h77, 3,0,1'b0,
                    2,1'b1,16'hF004,8'h3C,1'b1,1'b0,8'hA5};
        vecs[2] = '{1,0, 1,0, 0,0, 16'h0020,16'h0000, 8'h00,8'h00, 8'hEE, NEVER,0,1'b0,
                    1,1'b0,16'h0020,8'h00,1'b0,1'b1,8'hA5};
        vecs[3] = '{1,1, 0,1, 1,0, 16'h1234,16'hF100, 8'h11,8'h22, 8'h99, 1,0,1'b0,
                    1,1'b1,16'h1234,8'h11,1'b0,1'b0,8'hA5};
        vecs[4] = '{1,0, 1,0, 0,0, 16'h0040,16'h0000, 8'h00,8'h00, 8'h5A, 0,5,1'b0,
                    1,1'b0,16'h0040,8'h00,1'b0,1'b0,8'h5A};
        vecs[5] = '{0,1, 0,0, 1,1, 16'h0000,16'hEFFF, 8'h00,8'hC3, 8'h44, 2,0,1'b0,
                    2,1'b1,16'hEFFF,8'hC3,1'b0,1'b0,8'h5A};
        vecs[6] = '{0,1, 0,0, 1,0, 16'h0000,16'hF000, 8'h00,8'h0F, 8'h96, 15,0,1'b0,
                    2,1'b0,16'hF000,8'h0F,1'b1,1'b0,8'h96};
        vecs[7] = '{1,0, 1,0, 0,0, 16'hFFFF,16'h0000, 8'h12,8'h00, 8'h3B, 14,1,1'b0,
                    1,1'b0,16'hFFFF,8'h12,1'b1,1'b0,8'h3B};
        vecs[8] = '{1,0, 1,0, 0,0, 16'h0100,16'h0000, 8'h00,8'h00, 8'hE1, 2,0,1'b1,
                    1,1'b0,16'h0100,8'h00,1'b0,1'b0,8'hE1};
        vmid    = '{1,0, 1,0, 0,0, 16'h0200,16'h0000, 8'h00,8'h00, 8'h00, NEVER,0,1'b0,
                    1,1'b0,16'h0200,8'h00,1'b0,1'b0,8'h00};
        vpost   = '{0,1, 0,0, 0,1, 16'h0000,16'hF008, 8'h00,8'h5D, 8'h00, 0,0,1'b0,
                    2,1'b1,16'hF008,8'h5D,1'b1,1'b0,8'h00};

        clear_req();
        bus.M1_ADDR = 0; bus.M2_ADDR = 0; bus.M1_WDATA = 0; bus.M2_WDATA = 0;
        bus.S_RDATA = 0; bus.S_READY = 0;
        tick();
        tick();
        check("reset_outputs", 64'({bus.M_RDATA, bus.S_ADDR, bus.S_WDATA, strobes(), pulses()}), 64'd0);
        rst = 0;
        tick();

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Reset in the middle of a transfer clears outputs at once.
        drive(vmid);
        tick();
        check("mid_strobe", 64'({bus.S_READ, bus.S_ADDR}), 64'({1'b1, 16'h0200}));
        #2 rst = 1;
        #1;
        check("async_reset", 64'({bus.M_RDATA, bus.S_ADDR, bus.S_WDATA, strobes(), pulses()}), 64'd0);
        clear_req();
        tick();
        rst = 0;

        // Quiet after release, with stray S_READY while idle.
        quiet_bad = 0;
        bus.S_READY = 1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (pulses() != 0 || strobes() != 0 || bus.M_RDATA != 0) quiet_bad++;
        end
        bus.S_READY = 0;
        check("idle_quiet", 64'(quiet_bad), 64'd0);

        // A request held through reset is served as a fresh transfer.
        rst = 1;
        drive(vpost);
        tick();
        tick();
        rst = 0;
        run_vec(vpost);

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
